// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between four requesters and the shared 4:1 mux arbiter.
// The requester side drives req/din; the arbiter drives grant, select and mux output.
interface mux_rr_arbiter_if;
   logic [3:0] req;
   logic [3:0] din;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       valid;
   logic       y;

   modport master (output req, output din, input gnt, input sel, input valid, input y);
   modport slave  (input req, input din, output gnt, output sel, output valid, output y);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 one-bit mux with a bounded hold time
// per owner under contention; registered grant/select, combinational data gate.
module mux_rr_arbiter #(
   parameter  int HOLD_MAX = 4,
   localparam int CW       = $clog2(HOLD_MAX) + 1
) (
   input logic             clk,
   input logic             rst,
   mux_rr_arbiter_if.slave bus
);

   localparam logic [0:0]    S_IDLE  = 1'b0;
   localparam logic [0:0]    S_GRANT = 1'b1;
   localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

   logic [0:0]    state_q, state_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [1:0]    sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    last_q, last_d;

   logic       found;
   logic [1:0] win;
   logic       other_req;
   logic       hold_done;
   logic       take;

   // Returns {found, index}: first set bit scanning upward from lst+1, wrapping.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] lst);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 4; i >= 1; i--) begin
         idx = lst + 2'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign {found, win} = rr_pick(bus.req, last_q);
   assign other_req    = |(bus.req & ~gnt_q);
   assign hold_done    = (cnt_q == CNT_MAX);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      take    = 1'b0;
      case (state_q)
         S_IDLE: take = found;
         S_GRANT: begin
            if (!bus.req[sel_q]) begin
               // In GRANT last_q == sel_q, so the search already starts at owner+1.
               if (found) begin
                  take = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  gnt_d   = 4'b0000;
                  sel_d   = 2'd0;
                  cnt_d   = '0;
               end
            end else if (hold_done && other_req) begin
               take = 1'b1;
            end else if (hold_done) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (take) begin
         state_d = S_GRANT;
         gnt_d   = 4'b0001 << win;
         sel_d   = win;
         last_d  = win;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'd0;
         cnt_q   <= '0;
         last_q  <= 2'd3;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.sel   = sel_q;
   assign bus.valid = |gnt_q;
   assign bus.y     = bus.din[sel_q] & (|gnt_q);

endmodule
